uart_receive_controller: RTL and testbench

- UART receiver consuming the serial line driven by the TX path: the far-end TX pin in system use, or the local TX output in loopback.
- Uses the shared 16x oversampling baud_tick to detect the start bit, sample each bit at mid-bit and check the stop bit.
- Delivers bytes over a valid/ready holding register to the AXI-Lite register/FIFO layer.
- Reports framing and overrun errors as single-cycle pulses.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_synchronizer.sv | 28 ++
 rtl/uart_receive_controller.sv | 180 ++++++++++++++++++
 tb/tb_uart_receive_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame geometry used by
// both the RX and TX controllers.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    S_RX_IDLE         = 2'd0,
    S_RX_START_BIT    = 2'd1,
    S_RX_RECEIVE_BITS = 2'd2,
    S_RX_STOP_BIT     = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_synchronizer.sv
// Two-flop synchronizer for asynchronous serial inputs. Both stages reset to
// 1 so an idle-high line never looks like a start bit coming out of reset.
module uart_rx_synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture of the asynchronous input into the Clk domain.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      meta_r <= {WIDTH{1'b1}};
      sync_r <= {WIDTH{1'b1}};
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
    end
  end

  assign sync_out = sync_r;

endmodule

// File: rtl/uart_receive_controller.sv
// UART receiver: detects the start bit with the 16x oversampling tick, samples
// each data bit at mid-bit, checks the stop bit and hands completed bytes to a
// valid/ready holding register. Framing and overrun errors are one-cycle pulses.
// DATA_BITS must be at least 2; OVERSAMPLE must be even and at least 4.
module uart_receive_controller
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 Clk,
  input  logic                 Resetn,
  input  logic                 baud_tick,
  input  logic                 UART_RX_I,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_r, state_nxt_s;
  logic [TICK_W-1:0]    tick_r, tick_nxt_s;
  logic [BIT_W-1:0]     bit_r, bit_nxt_s;
  logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
  logic                 byte_done_s;
  logic                 stop_err_s;

  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 busy_r;
  logic                 frame_err_r;
  logic                 overrun_r;

  uart_rx_synchronizer #(
    .WIDTH (1)
  ) u_sync (
    .Clk      (Clk),
    .Resetn   (Resetn),
    .async_in (UART_RX_I),
    .sync_out (rx_s)
  );

  // Frame FSM state, bit/tick counters and the data shift register.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= S_RX_IDLE;
      tick_r  <= '0;
      bit_r   <= '0;
      shift_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      tick_r  <= tick_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
    end
  end

  // Next-state logic: start validation, mid-bit sampling and stop-bit check.
  always_comb begin
    state_nxt_s = state_r;
    tick_nxt_s  = tick_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    byte_done_s = 1'b0;
    stop_err_s  = 1'b0;
    case (state_r)
      S_RX_IDLE: begin
        tick_nxt_s = '0;
        if (!rx_s) begin
          state_nxt_s = S_RX_START_BIT;
        end else begin
          state_nxt_s = S_RX_IDLE;
        end
      end
      S_RX_START_BIT: begin
        if (baud_tick) begin
          if (tick_r == TICK_MID) begin
            // A line that is high again at mid start bit was only a glitch.
            tick_nxt_s = '0;
            if (!rx_s) begin
              state_nxt_s = S_RX_RECEIVE_BITS;
              bit_nxt_s   = '0;
            end else begin
              state_nxt_s = S_RX_IDLE;
            end
          end else begin
            tick_nxt_s = tick_r + TICK_W'(1);
          end
        end else begin
          tick_nxt_s = tick_r;
        end
      end
      S_RX_RECEIVE_BITS: begin
        if (baud_tick) begin
          if (tick_r == TICK_LAST) begin
            shift_nxt_s = {rx_s, shift_r[DATA_BITS-1:1]};
            bit_nxt_s   = bit_r + BIT_W'(1);
            tick_nxt_s  = '0;
            if (bit_r == BIT_LAST) begin
              state_nxt_s = S_RX_STOP_BIT;
            end else begin
              state_nxt_s = S_RX_RECEIVE_BITS;
            end
          end else begin
            tick_nxt_s = tick_r + TICK_W'(1);
          end
        end else begin
          tick_nxt_s = tick_r;
        end
      end
      S_RX_STOP_BIT: begin
        if (baud_tick) begin
          if (tick_r == TICK_LAST) begin
            // Leave at mid stop bit so a back-to-back start edge is not missed.
            tick_nxt_s  = '0;
            state_nxt_s = S_RX_IDLE;
            if (rx_s) begin
              byte_done_s = 1'b1;
            end else begin
              stop_err_s = 1'b1;
            end
          end else begin
            tick_nxt_s = tick_r + TICK_W'(1);
          end
        end else begin
          tick_nxt_s = tick_r;
        end
      end
      default: begin
        state_nxt_s = S_RX_IDLE;
        tick_nxt_s  = '0;
      end
    endcase
  end

  // Holding register, busy flag and single-cycle error pulses.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      busy_r      <= (state_nxt_s != S_RX_IDLE);
      frame_err_r <= stop_err_s;
      overrun_r   <= 1'b0;
      if (byte_done_s) begin
        if (!rx_valid_r || rx_ready) begin
          rx_data_r  <= shift_r;
          rx_valid_r <= 1'b1;
        end else begin
          // Consumer still holds the previous byte: keep it, drop the new one.
          overrun_r <= 1'b1;
        end
      end else if (rx_valid_r && rx_ready) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
    end
  end

  assign rx_data      = rx_data_r;
  assign rx_valid     = rx_valid_r;
  assign rx_busy      = busy_r;
  assign rx_frame_err = frame_err_r;
  assign rx_overrun   = overrun_r;

endmodule

// File: tb/tb_uart_receive_controller.sv
// Self-checking bench for uart_receive_controller: drives serial frames on
// UART_RX_I with baud_tick every 4 Clk, keeps expected bytes in a scoreboard
// queue and records DUT events (handshakes, error pulses) in a monitor.
module tb_uart_receive_controller;

  localparam int TICK_CLK = 4;
  localparam int OS       = 16;
  localparam int BIT_CLK  = OS * TICK_CLK;

  logic       Clk = 1'b0;
  logic       Resetn;
  logic       baud_tick;
  logic       UART_RX_I;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_frame_err;
  logic       rx_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  int cyc       = 0;
  int edge_cyc  = 0;
  int rise_cyc  = 0;
  int ferr_cnt  = 0;
  int ferr_long = 0;
  int ovr_cnt   = 0;
  int ovr_long  = 0;
  int vrise_cnt = 0;

  uart_receive_controller dut (
    .Clk          (Clk),
    .Resetn       (Resetn),
    .baud_tick    (baud_tick),
    .UART_RX_I    (UART_RX_I),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  initial forever #5 Clk = ~Clk;

  // Baud tick: one Clk wide, every TICK_CLK cycles, changed on falling edges.
  initial begin
    int cnt;
    cnt = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge Clk);
      cyc = cyc + 1;
      baud_tick = (cnt == 0);
      cnt = (cnt + 1) % TICK_CLK;
    end
  end

  // Monitor: log handshakes, error pulses (and their widths) and rx_valid rises.
  initial begin
    logic prev_ferr, prev_ovr, prev_valid;
    prev_ferr = 1'b0; prev_ovr = 1'b0; prev_valid = 1'b0;
    forever begin
      @(negedge Clk);
      #2;
      if (rx_valid === 1'b1 && rx_ready === 1'b1) got_q.push_back(rx_data);
      if (rx_frame_err === 1'b1) begin
        ferr_cnt = ferr_cnt + 1;
        if (prev_ferr) ferr_long = ferr_long + 1;
      end
      if (rx_overrun === 1'b1) begin
        ovr_cnt = ovr_cnt + 1;
        if (prev_ovr) ovr_long = ovr_long + 1;
      end
      if (rx_valid === 1'b1 && !prev_valid) begin
        vrise_cnt = vrise_cnt + 1;
        rise_cyc  = cyc;
      end
      prev_ferr  = rx_frame_err;
      prev_ovr   = rx_overrun;
      prev_valid = rx_valid;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic sync_tick();
    do @(posedge Clk); while (baud_tick !== 1'b1);
    @(negedge Clk);
  endtask

  // Full frame: start, 8 data bits LSB first, stop (or a stop bit held low
  // for its first 40 Clk, then released high for the rest of the bit time).
  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    UART_RX_I = 1'b0;
    edge_cyc  = cyc;
    repeat (BIT_CLK) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      UART_RX_I = d[i];
      repeat (BIT_CLK) @(negedge Clk);
    end
    if (stop_ok) begin
      UART_RX_I = 1'b1;
      repeat (BIT_CLK) @(negedge Clk);
    end else begin
      UART_RX_I = 1'b0;
      repeat (40) @(negedge Clk);
      UART_RX_I = 1'b1;
      repeat (BIT_CLK - 40) @(negedge Clk);
    end
  endtask

  task automatic wait_valid(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (rx_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge Clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %0h expected 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", rx_valid); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", rx_busy); end
    n_checks++; if (rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %0b expected 0", rx_frame_err); end
    n_checks++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %0b expected 0", rx_overrun); end
    Resetn = 1'b1;
    repeat (20) @(negedge Clk);
    n_checks++; if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got busy=%0b valid=%0b expected 0 0", rx_busy, rx_valid); end
  endtask

  task automatic test_single_byte();
    bit seen; logic [7:0] e; int f0, o0, lat;
    f0 = ferr_cnt; o0 = ovr_cnt;
    rx_ready = 1'b0;
    exp_q.push_back(8'hA5);
    sync_tick();
    send_frame(8'hA5, 1'b1);
    wait_valid(300, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL a5_valid_timeout: got valid=%0b expected 1", rx_valid); end
    e = exp_q.pop_front();
    n_checks++; if (rx_data !== e) begin n_fail++; $display("FAIL a5_data: got %0h expected %0h", rx_data, e); end
    lat = rise_cyc - edge_cyc;
    n_checks++; if (lat < 600 || lat > 620) begin n_fail++; $display("FAIL a5_latency: got %0d Clk expected 600..620", lat); end
    n_checks++; if (ferr_cnt != f0 || ovr_cnt != o0) begin n_fail++; $display("FAIL a5_errors: got ferr=%0d ovr=%0d expected 0 0", ferr_cnt - f0, ovr_cnt - o0); end
    consume();
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL a5_consume: got valid=%0b expected 0", rx_valid); end
  endtask

  task automatic test_glitch();
    int f0, v0;
    f0 = ferr_cnt; v0 = vrise_cnt;
    sync_tick();
    UART_RX_I = 1'b0;
    repeat (10) @(negedge Clk);
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise: got %0b expected 1", rx_busy); end
    repeat (10) @(negedge Clk);
    UART_RX_I = 1'b1;
    repeat (40) @(negedge Clk);
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_fall: got %0b expected 0", rx_busy); end
    n_checks++; if (rx_valid !== 1'b0 || vrise_cnt != v0) begin n_fail++; $display("FAIL glitch_valid: got valid=%0b rises=%0d expected 0 0", rx_valid, vrise_cnt - v0); end
    n_checks++; if (ferr_cnt != f0) begin n_fail++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt - f0); end
  endtask

  task automatic test_frame_error();
    bit seen; logic [7:0] e; int f0, fl0, v0;
    f0 = ferr_cnt; fl0 = ferr_long; v0 = vrise_cnt;
    sync_tick();
    send_frame(8'h3C, 1'b0);
    repeat (100) @(negedge Clk);
    n_checks++; if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
    n_checks++; if (ferr_long != fl0) begin n_fail++; $display("FAIL ferr_width: got %0d long pulses expected 0", ferr_long - fl0); end
    n_checks++; if (rx_valid !== 1'b0 || vrise_cnt != v0) begin n_fail++; $display("FAIL ferr_valid: got valid=%0b rises=%0d expected 0 0", rx_valid, vrise_cnt - v0); end
    exp_q.push_back(8'h81);
    sync_tick();
    send_frame(8'h81, 1'b1);
    wait_valid(300, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL ferr_next_timeout: got valid=%0b expected 1", rx_valid); end
    e = exp_q.pop_front();
    n_checks++; if (rx_data !== e) begin n_fail++; $display("FAIL ferr_next_data: got %0h expected %0h", rx_data, e); end
    n_checks++; if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL ferr_next_err: got %0d expected 1", ferr_cnt - f0); end
    consume();
  endtask

  task automatic test_overrun();
    logic [7:0] e; int o0, ol0, f0;
    o0 = ovr_cnt; ol0 = ovr_long; f0 = ferr_cnt;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    sync_tick();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (20) @(negedge Clk);
    n_checks++; if (ovr_cnt - o0 != 1) begin n_fail++; $display("FAIL ovr_count: got %0d expected 1", ovr_cnt - o0); end
    n_checks++; if (ovr_long != ol0) begin n_fail++; $display("FAIL ovr_width: got %0d long pulses expected 0", ovr_long - ol0); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %0b expected 1", rx_valid); end
    e = exp_q.pop_front();
    n_checks++; if (rx_data !== e) begin n_fail++; $display("FAIL ovr_data: got %0h expected %0h", rx_data, e); end
    n_checks++; if (ferr_cnt != f0) begin n_fail++; $display("FAIL ovr_ferr: got %0d expected 0", ferr_cnt - f0); end
    consume();
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_consume: got valid=%0b expected 0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, g; int o0, f0;
    o0 = ovr_cnt; f0 = ferr_cnt;
    got_q.delete();
    rx_ready = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    sync_tick();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    repeat (100) @(negedge Clk);
    rx_ready = 1'b0;
    n_checks++; if (got_q.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d bytes expected 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      g = 8'hxx;
      if (got_q.size() > 0) g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL b2b_data%0d: got %0h expected %0h", i, g, e); end
    end
    n_checks++; if (ovr_cnt != o0 || ferr_cnt != f0) begin n_fail++; $display("FAIL b2b_errors: got ovr=%0d ferr=%0d expected 0 0", ovr_cnt - o0, ferr_cnt - f0); end
  endtask

  task automatic test_reset_mid_frame();
    bit seen; logic [7:0] e, d; int f0, o0;
    d = 8'hC3;
    rx_ready = 1'b0;
    sync_tick();
    UART_RX_I = 1'b0;
    repeat (BIT_CLK) @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      UART_RX_I = d[i];
      repeat (BIT_CLK) @(negedge Clk);
    end
    UART_RX_I = d[4];
    repeat (BIT_CLK / 2) @(negedge Clk);
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %0b expected 1", rx_busy); end
    Resetn = 1'b0;
    #1;
    n_checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_outs: got data=%0h valid=%0b busy=%0b expected 00 0 0", rx_data, rx_valid, rx_busy); end
    n_checks++; if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin n_fail++; $display("FAIL mid_reset_errs: got ferr=%0b ovr=%0b expected 0 0", rx_frame_err, rx_overrun); end
    @(negedge Clk);
    UART_RX_I = 1'b1;
    repeat (4) @(negedge Clk);
    f0 = ferr_cnt; o0 = ovr_cnt;
    Resetn = 1'b1;
    repeat (10) @(negedge Clk);
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_after_busy: got %0b expected 0", rx_busy); end
    exp_q.push_back(8'h7E);
    sync_tick();
    send_frame(8'h7E, 1'b1);
    wait_valid(300, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_next_timeout: got valid=%0b expected 1", rx_valid); end
    e = exp_q.pop_front();
    n_checks++; if (rx_data !== e) begin n_fail++; $display("FAIL mid_next_data: got %0h expected %0h", rx_data, e); end
    n_checks++; if (ferr_cnt != f0 || ovr_cnt != o0) begin n_fail++; $display("FAIL mid_next_errors: got ferr=%0d ovr=%0d expected 0 0", ferr_cnt - f0, ovr_cnt - o0); end
    consume();
  endtask

  initial begin
    Resetn    = 1'b0;
    UART_RX_I = 1'b1;
    rx_ready  = 1'b0;
    repeat (5) @(negedge Clk);
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
